// File: rtl/layer_cfg_pkg.sv
// Shared definitions for the layer control-register initiator:
// FSM encodings, default bus geometry and timeout counter sizing.
package layer_cfg_pkg;

   localparam int DEF_BUS_WIDTH      = 32;
   localparam int DEF_ADDR_WIDTH     = 10;
   localparam int DEF_TIMEOUT_CYCLES = 1024;
   localparam int DEF_TO_CNT_W       = $clog2(DEF_TIMEOUT_CYCLES);

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_WR_REQ  = 3'd1;
   localparam state_t ST_WR_RESP = 3'd2;
   localparam state_t ST_RD_REQ  = 3'd3;
   localparam state_t ST_RD_DATA = 3'd4;
   localparam state_t ST_RSP     = 3'd5;

   function automatic int to_cnt_width(input int cycles);
      return (cycles > 2) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/layer_cfg_timeout_cnt.sv
// Per-transaction watchdog: cleared at command acceptance, counts while a bus
// transaction is outstanding, flags expiry at LIMIT-1 and saturates there.
module cfg_timeout_cnt
   import layer_cfg_pkg::*;
#(
   parameter int LIMIT = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W = DEF_TO_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_r;
   logic             expired_s;

   assign expired_s = (count_r == LAST);
   assign expired   = expired_s;

   // Cycle counter with clear priority over enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else if (enable && !expired_s) begin
         count_r <= count_r + ONE;
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/layer_cfg_master.sv
// Single-command AXI4-Lite-style initiator for a CNN layer's control slave.
// Every output is a flop loaded from the next-state logic below.
module layer_cfg_master
   import layer_cfg_pkg::*;
#(
   parameter int AXI_BUS_WIDTH  = DEF_BUS_WIDTH,
   parameter int AXI_ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                      axi_clk,
   input  logic                      axi_reset_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [AXI_BUS_WIDTH-1:0]  cmd_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [AXI_BUS_WIDTH-1:0]  rsp_rdata,
   output logic                      rsp_timeout,
   output logic                      rsp_last_err,
   output logic                      busy,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [AXI_BUS_WIDTH-1:0]  m_axi_wdata,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [AXI_BUS_WIDTH-1:0]  m_axi_rdata,
   input  logic                      m_axi_rvalid,
   input  logic                      m_axi_rlast,
   output logic                      m_axi_rready
);

   localparam int CNT_W = to_cnt_width(TIMEOUT_CYCLES);
   localparam logic [AXI_BUS_WIDTH-1:0]  ZERO_DATA = {AXI_BUS_WIDTH{1'b0}};
   localparam logic [AXI_ADDR_WIDTH-1:0] ZERO_ADDR = {AXI_ADDR_WIDTH{1'b0}};

   state_t                      state_r, state_s;
   logic                        cmd_ready_r, busy_r;
   logic [AXI_ADDR_WIDTH-1:0]   addr_r, addr_s;
   logic [AXI_BUS_WIDTH-1:0]    wdata_r, wdata_s;
   logic                        awvalid_r, awvalid_s, wvalid_r, wvalid_s, bready_r, bready_s;
   logic                        arvalid_r, arvalid_s, rready_r, rready_s;
   logic                        rsp_valid_r, rsp_valid_s, rsp_timeout_r, rsp_timeout_s;
   logic                        rsp_last_err_r, rsp_last_err_s;
   logic [AXI_BUS_WIDTH-1:0]    rsp_rdata_r, rsp_rdata_s;
   logic                        cnt_clear_s, cnt_en_s, to_expired_s;
   logic                        aw_done_s, w_done_s, finish_s, abort_s;

   assign aw_done_s = !awvalid_r || m_axi_awready;
   assign w_done_s  = !wvalid_r  || m_axi_wready;
   assign cnt_en_s  = (state_r == ST_WR_REQ) || (state_r == ST_WR_RESP) ||
                      (state_r == ST_RD_REQ) || (state_r == ST_RD_DATA);
   // A response arriving in the expiry cycle still completes normally.
   assign finish_s  = ((state_r == ST_WR_RESP) && m_axi_bvalid) ||
                      ((state_r == ST_RD_DATA) && m_axi_rvalid);
   assign abort_s   = cnt_en_s && to_expired_s && !finish_s;

   cfg_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES),
      .CNT_W (CNT_W)
   ) u_timeout (
      .clk     (axi_clk),
      .rst_n   (axi_reset_n),
      .clear   (cnt_clear_s),
      .enable  (cnt_en_s),
      .expired (to_expired_s)
   );

   // Next-state and next-output computation for the transaction FSM.
   always_comb begin
      state_s        = state_r;
      addr_s         = addr_r;
      wdata_s        = wdata_r;
      awvalid_s      = awvalid_r;
      wvalid_s       = wvalid_r;
      bready_s       = bready_r;
      arvalid_s      = arvalid_r;
      rready_s       = rready_r;
      rsp_valid_s    = rsp_valid_r;
      rsp_rdata_s    = rsp_rdata_r;
      rsp_timeout_s  = rsp_timeout_r;
      rsp_last_err_s = rsp_last_err_r;
      cnt_clear_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               cnt_clear_s = 1'b1;
               addr_s      = cmd_addr;
               if (cmd_write) begin
                  wdata_s   = cmd_wdata;
                  awvalid_s = 1'b1;
                  wvalid_s  = 1'b1;
                  state_s   = ST_WR_REQ;
               end else begin
                  arvalid_s = 1'b1;
                  state_s   = ST_RD_REQ;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WR_REQ: begin
            awvalid_s = awvalid_r && !m_axi_awready;
            wvalid_s  = wvalid_r  && !m_axi_wready;
            if (aw_done_s && w_done_s) begin
               bready_s = 1'b1;
               state_s  = ST_WR_RESP;
            end else begin
               state_s = ST_WR_REQ;
            end
         end
         ST_WR_RESP: begin
            if (m_axi_bvalid) begin
               bready_s       = 1'b0;
               rsp_valid_s    = 1'b1;
               rsp_rdata_s    = ZERO_DATA;
               rsp_timeout_s  = 1'b0;
               rsp_last_err_s = 1'b0;
               state_s        = ST_RSP;
            end else begin
               state_s = ST_WR_RESP;
            end
         end
         ST_RD_REQ: begin
            if (m_axi_arready) begin
               arvalid_s = 1'b0;
               rready_s  = 1'b1;
               state_s   = ST_RD_DATA;
            end else begin
               state_s = ST_RD_REQ;
            end
         end
         ST_RD_DATA: begin
            if (m_axi_rvalid) begin
               rready_s       = 1'b0;
               rsp_valid_s    = 1'b1;
               rsp_rdata_s    = m_axi_rdata;
               rsp_timeout_s  = 1'b0;
               rsp_last_err_s = !m_axi_rlast;
               state_s        = ST_RSP;
            end else begin
               state_s = ST_RD_DATA;
            end
         end
         ST_RSP: begin
            if (rsp_ready) begin
               rsp_valid_s    = 1'b0;
               rsp_rdata_s    = ZERO_DATA;
               rsp_timeout_s  = 1'b0;
               rsp_last_err_s = 1'b0;
               state_s        = ST_IDLE;
            end else begin
               state_s = ST_RSP;
            end
         end
         default: begin
            state_s        = ST_IDLE;
            awvalid_s      = 1'b0;
            wvalid_s       = 1'b0;
            bready_s       = 1'b0;
            arvalid_s      = 1'b0;
            rready_s       = 1'b0;
            rsp_valid_s    = 1'b0;
            rsp_rdata_s    = ZERO_DATA;
            rsp_timeout_s  = 1'b0;
            rsp_last_err_s = 1'b0;
         end
      endcase
      // Abort drops every bus handshake at once; the layer is reset afterwards.
      if (abort_s) begin
         awvalid_s      = 1'b0;
         wvalid_s       = 1'b0;
         bready_s       = 1'b0;
         arvalid_s      = 1'b0;
         rready_s       = 1'b0;
         rsp_valid_s    = 1'b1;
         rsp_rdata_s    = ZERO_DATA;
         rsp_timeout_s  = 1'b1;
         rsp_last_err_s = 1'b0;
         state_s        = ST_RSP;
      end else begin
         state_s = state_s;
      end
   end

   // State and registered output flops.
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         state_r        <= ST_IDLE;
         cmd_ready_r    <= 1'b0;
         busy_r         <= 1'b0;
         addr_r         <= ZERO_ADDR;
         wdata_r        <= ZERO_DATA;
         awvalid_r      <= 1'b0;
         wvalid_r       <= 1'b0;
         bready_r       <= 1'b0;
         arvalid_r      <= 1'b0;
         rready_r       <= 1'b0;
         rsp_valid_r    <= 1'b0;
         rsp_rdata_r    <= ZERO_DATA;
         rsp_timeout_r  <= 1'b0;
         rsp_last_err_r <= 1'b0;
      end else begin
         state_r        <= state_s;
         cmd_ready_r    <= (state_s == ST_IDLE);
         busy_r         <= (state_s != ST_IDLE);
         addr_r         <= addr_s;
         wdata_r        <= wdata_s;
         awvalid_r      <= awvalid_s;
         wvalid_r       <= wvalid_s;
         bready_r       <= bready_s;
         arvalid_r      <= arvalid_s;
         rready_r       <= rready_s;
         rsp_valid_r    <= rsp_valid_s;
         rsp_rdata_r    <= rsp_rdata_s;
         rsp_timeout_r  <= rsp_timeout_s;
         rsp_last_err_r <= rsp_last_err_s;
      end
   end

   assign cmd_ready     = cmd_ready_r;
   assign busy          = busy_r;
   assign m_axi_awaddr  = addr_r;
   assign m_axi_araddr  = addr_r;
   assign m_axi_wdata   = wdata_r;
   assign m_axi_awvalid = awvalid_r;
   assign m_axi_wvalid  = wvalid_r;
   assign m_axi_bready  = bready_r;
   assign m_axi_arvalid = arvalid_r;
   assign m_axi_rready  = rready_r;
   assign rsp_valid     = rsp_valid_r;
   assign rsp_rdata     = rsp_rdata_r;
   assign rsp_timeout   = rsp_timeout_r;
   assign rsp_last_err  = rsp_last_err_r;

endmodule

// File: tb/tb_layer_cfg_master.sv
// Scoreboard bench for layer_cfg_master: a driver/slave process issues commands
// and pushes model predictions; a monitor pops them on each response handshake.
module tb_layer_cfg_master;

   localparam int T = 16;

   logic        clk, axi_reset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [9:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_timeout, rsp_last_err, busy;
   logic [31:0] rsp_rdata;
   logic [9:0]  awaddr, araddr;
   logic [31:0] wdata, rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rlast, rready;

   typedef struct {
      bit          write;
      logic [9:0]  addr;
      logic [31:0] wdata;
      int          aw, w, b, ar, r;
      bit          rlast;
      int          hold;
      bit          keep;
      int          mode;
   } txn_t;

   typedef struct {
      logic [31:0] rdata;
      bit          to;
      bit          le;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem[logic [9:0]];
   logic [31:0] slave_mem[logic [9:0]];
   logic [9:0]  aw_l, ar_l;
   logic [31:0] w_l;
   int          total = 0;
   int          bad = 0;

   layer_cfg_master #(
      .AXI_BUS_WIDTH  (32),
      .AXI_ADDR_WIDTH (10),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .axi_clk       (clk),
      .axi_reset_n   (axi_reset_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_timeout   (rsp_timeout),
      .rsp_last_err  (rsp_last_err),
      .busy          (busy),
      .m_axi_awaddr  (awaddr),
      .m_axi_awvalid (awvalid),
      .m_axi_awready (awready),
      .m_axi_wdata   (wdata),
      .m_axi_wvalid  (wvalid),
      .m_axi_wready  (wready),
      .m_axi_bvalid  (bvalid),
      .m_axi_bready  (bready),
      .m_axi_araddr  (araddr),
      .m_axi_arvalid (arvalid),
      .m_axi_arready (arready),
      .m_axi_rdata   (rdata),
      .m_axi_rvalid  (rvalid),
      .m_axi_rlast   (rlast),
      .m_axi_rready  (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("watchdog expired at %0t", $time);
      $fatal(1, "bench did not terminate");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ctl"}, {22'd0, cmd_ready, busy, awvalid, wvalid, bready,
                          arvalid, rready, rsp_valid, rsp_timeout, rsp_last_err}, 32'd0);
      chk({tag, "_addr"}, {12'd0, awaddr, araddr}, 32'd0);
      chk({tag, "_wdata"}, wdata, 32'd0);
      chk({tag, "_rdata"}, rsp_rdata, 32'd0);
   endtask

   // Reference: a transaction finishes when its last handshake lands; if that
   // would be after cycle T (or the request phase is still open at T) it times out.
   function automatic exp_t model(input txn_t t, output int rsp_cyc);
      int   req, fin;
      bit   to;
      exp_t e;
      if (t.write) begin
         req = (t.aw > t.w) ? t.aw : t.w;
         fin = (req + 1 > t.b) ? req + 1 : t.b;
      end else begin
         req = t.ar;
         fin = (req + 1 > t.r) ? req + 1 : t.r;
      end
      to      = (req >= T) || (fin > T);
      rsp_cyc = (to ? T : fin) + 1;
      e.to    = to;
      e.le    = !to && !t.write && !t.rlast;
      if (to || t.write) e.rdata = 32'h0;
      else e.rdata = ref_mem.exists(t.addr) ? ref_mem[t.addr] : 32'h0;
      if (t.write && !to) ref_mem[t.addr] = t.wdata;
      return e;
   endfunction

   function automatic txn_t mk(input bit wr, input logic [9:0] a, input logic [31:0] d,
                               input int aw, input int w, input int b, input int ar,
                               input int r, input bit rl, input int hold, input bit keep,
                               input int mode);
      txn_t t;
      t.write = wr; t.addr = a; t.wdata = d; t.aw = aw; t.w = w; t.b = b;
      t.ar = ar; t.r = r; t.rlast = rl; t.hold = hold; t.keep = keep; t.mode = mode;
      return t;
   endfunction

   // Entered and left at posedge+1; plays host and slave for one command.
   task automatic run_txn(input txn_t t);
      exp_t        e;
      int          waits, c, exp_rsp;
      bit          done, b_done, r_done, snap_v;
      logic [31:0] snap_d;
      logic [2:0]  snap_f;
      cmd_valid = 1'b1; cmd_write = t.write; cmd_addr = t.addr; cmd_wdata = t.wdata;
      waits = 0;
      @(negedge clk);
      while (!cmd_ready && waits < 20) begin
         waits++;
         @(negedge clk);
      end
      chk("cmd_accept_wait", waits, 32'd0);
      if (!cmd_ready) begin
         cmd_valid = 1'b0;
         return;
      end
      e = model(t, exp_rsp);
      exp_q.push_back(e);
      @(posedge clk); #1;
      cmd_valid = t.keep; cmd_write = 1'($urandom); cmd_addr = 10'($urandom); cmd_wdata = $urandom;
      done = 1'b0; b_done = 1'b0; r_done = 1'b0; snap_v = 1'b0;
      for (c = 1; c <= 60 && !done; c++) begin
         awready   = (c >= t.aw);
         wready    = (c >= t.w);
         arready   = (c >= t.ar);
         bvalid    = (c >= t.b) && !b_done;
         rvalid    = (c >= t.r) && !r_done;
         rlast     = t.rlast;
         rdata     = slave_mem.exists(ar_l) ? slave_mem[ar_l] : 32'h0;
         rsp_ready = (c >= exp_rsp + t.hold);
         @(negedge clk);
         if (c == exp_rsp - 1) chk("rsp_early", rsp_valid, 32'd0);
         if (c == exp_rsp) chk("rsp_rise", rsp_valid, 32'd1);
         if (c == 1) chk("busy", busy, 32'd1);
         case (t.mode)
            1: begin
               if (c == 2) chk("awvalid_drop", awvalid, 32'd0);
               if (c == 5) chk("wvalid_hold_bready_low", {wvalid, bready}, 32'd2);
               if (c == 6) chk("wvalid_drop_bready_high", {wvalid, bready}, 32'd1);
            end
            2: begin
               if (c == T) chk("arvalid_before_to", arvalid, 32'd1);
               if (c == T + 1) chk("arvalid_after_to", {arvalid, rsp_timeout}, 32'd1);
            end
            3: begin
               if (c == 1) chk("wr_req_valids", {awvalid, wvalid}, 32'd3);
               if (c == 1) chk("wr_req_addr", awaddr, 32'h004);
               if (c == 1) chk("wr_req_data", wdata, 32'h55);
            end
            4: chk("cmd_ready_low", cmd_ready, 32'd0);
            default: ;
         endcase
         if (snap_v) begin
            chk("rsp_stable_flags", {rsp_valid, rsp_timeout, rsp_last_err}, snap_f);
            chk("rsp_stable_data", rsp_rdata, snap_d);
         end
         snap_v = rsp_valid && !rsp_ready;
         snap_f = {rsp_valid, rsp_timeout, rsp_last_err};
         snap_d = rsp_rdata;
         if (awvalid && awready) aw_l = awaddr;
         if (wvalid && wready) w_l = wdata;
         if (bvalid && bready) begin
            b_done = 1'b1;
            slave_mem[aw_l] = w_l;
         end
         if (arvalid && arready) ar_l = araddr;
         if (rvalid && rready) r_done = 1'b1;
         if (rsp_valid && rsp_ready) done = 1'b1;
         @(posedge clk); #1;
      end
      chk("rsp_handshake_seen", done, 32'd1);
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      rsp_ready = 1'b0;
   endtask

   // Monitor: every response handshake is checked against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (axi_reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_timeout", rsp_timeout, {31'd0, e.to});
               chk("rsp_last_err", rsp_last_err, {31'd0, e.le});
            end
         end
      end
   end

   initial begin
      txn_t t;
      bit   hang;
      axi_reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 10'd0;
      cmd_wdata = 32'd0; rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0;
      bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
      aw_l = 10'd0; ar_l = 10'd0; w_l = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      axi_reset_n = 1'b1;
      @(posedge clk); #1;
      chk("cmd_ready_after_reset", cmd_ready, 32'd1);

      // Directed cases: basic write, delayed wready, reads with rlast 1/0, timeout, stall.
      run_txn(mk(1'b1, 10'h004, 32'h0000_0055, 1, 1, 1, 999, 999, 1'b1, 0, 1'b0, 3));
      run_txn(mk(1'b1, 10'h00C, 32'h1357_9BDF, 1, 5, 1, 999, 999, 1'b1, 0, 1'b0, 1));
      run_txn(mk(1'b1, 10'h008, 32'hDEAD_BEEF, 1, 1, 1, 999, 999, 1'b1, 1, 1'b0, 0));
      run_txn(mk(1'b0, 10'h008, 32'h0, 999, 999, 999, 1, 5, 1'b1, 0, 1'b0, 0));
      run_txn(mk(1'b0, 10'h008, 32'h0, 999, 999, 999, 1, 5, 1'b0, 0, 1'b0, 0));
      run_txn(mk(1'b0, 10'h020, 32'h0, 999, 999, 999, 999, 999, 1'b1, 0, 1'b0, 2));
      run_txn(mk(1'b0, 10'h004, 32'h0, 999, 999, 999, 1, 2, 1'b1, 10, 1'b1, 4));
      run_txn(mk(1'b0, 10'h00C, 32'h0, 999, 999, 999, 2, 3, 1'b1, 0, 1'b0, 0));

      for (int i = 0; i < 40; i++) begin
         t.write = 1'($urandom_range(0, 1));
         t.addr  = 10'($urandom_range(0, 15) * 4);
         t.wdata = $urandom;
         t.aw    = $urandom_range(1, 4);
         t.w     = $urandom_range(1, 4);
         t.b     = $urandom_range(1, 6);
         t.ar    = $urandom_range(1, 4);
         t.r     = $urandom_range(1, 7);
         t.rlast = ($urandom_range(0, 3) != 0);
         t.hold  = $urandom_range(0, 3);
         t.keep  = (i != 39) && ($urandom_range(0, 1) == 1);
         t.mode  = 0;
         hang    = ($urandom_range(0, 9) == 0);
         if (hang && t.write) t.b = 999;
         if (hang && !t.write) begin
            if ($urandom_range(0, 1) == 1) t.ar = 999;
            else t.r = 999;
         end
         run_txn(t);
      end

      // Reset while waiting for the write response: command is dropped silently.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h010; cmd_wdata = 32'h1234_5678;
      @(negedge clk);
      chk("rst_test_accept", cmd_ready, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
      @(posedge clk); #1;
      awready = 1'b0; wready = 1'b0;
      @(negedge clk);
      chk("rst_test_in_wr_resp", {bready, busy}, 32'd3);
      axi_reset_n = 1'b0;
      #1;
      chk_reset_vals("mid_reset");
      repeat (2) begin
         @(negedge clk);
         chk("mid_reset_no_rsp", rsp_valid, 32'd0);
      end
      axi_reset_n = 1'b1;
      @(posedge clk); #1;
      run_txn(mk(1'b1, 10'h010, 32'hA5A5_0F0F, 1, 1, 1, 999, 999, 1'b1, 0, 1'b0, 0));
      run_txn(mk(1'b0, 10'h010, 32'h0, 999, 999, 999, 1, 2, 1'b1, 0, 1'b0, 0));

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
